// File: rtl/axil_ptgen_pkg.sv
// Shared state/response types and the pattern LFSR used by the AXI-Lite pattern master.
package axil_ptgen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      PAT_INC  = 1'b0,
      PAT_LFSR = 1'b1
   } pattern_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Right-shifting Galois taps: x^32+x^22+x^2+x+1 and x^64+x^63+x^61+x^60+1.
   localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
   localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

   function automatic logic [63:0] lfsr_next(input logic [63:0] s, input logic wide);
      logic [63:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ (wide ? LFSR_TAPS_64 : LFSR_TAPS_32);
      end
      return n;
   endfunction

endpackage

// File: rtl/axil_ptgen_pattern.sv
// Beat index and data pattern generator; reloaded at the start of each phase so the
// read phase replays exactly the sequence the write phase produced.
module axil_ptgen_pattern
   import axil_ptgen_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          IDX_W      = 2,
   parameter int          PATTERN    = 0,
   parameter logic [63:0] SEED       = 64'h1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  advance,
   output logic [IDX_W-1:0]      idx,
   output logic [DATA_WIDTH-1:0] data
);

   localparam pattern_e    PAT       = (PATTERN == 1) ? PAT_LFSR : PAT_INC;
   localparam logic        WIDE      = (DATA_WIDTH == 64);
   localparam logic [63:0] SEED_MASK = WIDE ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
   localparam logic [63:0] SEED_EFF  = ((SEED & SEED_MASK) == 64'd0) ? 64'd1 : (SEED & SEED_MASK);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [63:0]      lfsr_q, lfsr_d;

   always_comb begin
      idx_d  = idx_q;
      lfsr_d = lfsr_q;
      if (load) begin
         idx_d  = '0;
         lfsr_d = SEED_EFF;
      end else if (advance) begin
         idx_d  = idx_q + IDX_W'(1);
         lfsr_d = lfsr_next(lfsr_q, WIDE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         lfsr_q <= SEED_EFF;
      end else begin
         idx_q  <= idx_d;
         lfsr_q <= lfsr_d;
      end
   end

   assign idx  = idx_q;
   assign data = (PAT == PAT_LFSR) ? lfsr_q[DATA_WIDTH-1:0]
                                   : DATA_WIDTH'(idx_q) + DATA_WIDTH'(1);

endmodule

// File: rtl/axil_ptgen_master.sv
// Self-checking AXI4-Lite traffic master: writes NUM_TXN pattern beats from BASE_ADDR,
// reads them back, and reports done / sticky error / saturating failing-beat count.
module axil_ptgen_master
   import axil_ptgen_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_TXN    = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h4000_0000,
   parameter int                    PATTERN    = 0,
   parameter logic [63:0]           SEED       = 64'h1,
   parameter int                    ERR_CNT_W  = 8
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      INIT_TXN,
   output logic                      BUSY,
   output logic                      TXN_DONE,
   output logic                      ERROR,
   output logic [ERR_CNT_W-1:0]      ERR_COUNT,
   output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                M_AXI_AWPROT,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                M_AXI_ARPROT,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY
);

   localparam int                    IDX_W    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_TXN - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(DATA_WIDTH / 8);

   state_t                  state_q, state_d;
   logic                    init_q, init_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic                    issue_q, issue_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

   logic                    start, fail, pat_load, pat_adv, last_beat;
   logic [IDX_W-1:0]        pat_idx;
   logic [DATA_WIDTH-1:0]   pat_data;

   axil_ptgen_pattern #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W),
      .PATTERN    (PATTERN),
      .SEED       (SEED)
   ) u_pattern (
      .clk     (ACLK),
      .rst     (ARESET),
      .load    (pat_load),
      .advance (pat_adv),
      .idx     (pat_idx),
      .data    (pat_data)
   );

   assign start     = INIT_TXN && !init_q && ((state_q == IDLE) || (state_q == DONE));
   assign last_beat = (pat_idx == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      init_d    = INIT_TXN;
      busy_d    = busy_q;
      done_d    = done_q;
      error_d   = error_q;
      err_cnt_d = err_cnt_q;
      issue_d   = issue_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      fail      = 1'b0;
      pat_load  = 1'b0;
      pat_adv   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = WRITE;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               error_d   = 1'b0;
               err_cnt_d = '0;
               issue_d   = 1'b1;
               bready_d  = 1'b1;
               awaddr_d  = BASE_ADDR;
               pat_load  = 1'b1;
            end
         end
         WRITE: begin
            // The issue cycle lets the pattern settle after an advance before WDATA is latched.
            if (issue_q) begin
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               wdata_d   = pat_data;
               issue_d   = 1'b0;
            end
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
            if (M_AXI_BVALID && bready_q) begin
               fail = (M_AXI_BRESP != OKAY);
               if (last_beat) begin
                  state_d   = READ;
                  bready_d  = 1'b0;
                  rready_d  = 1'b1;
                  arvalid_d = 1'b1;
                  araddr_d  = BASE_ADDR;
                  pat_load  = 1'b1;
               end else begin
                  pat_adv  = 1'b1;
                  awaddr_d = awaddr_q + STEP;
                  issue_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (arvalid_q && M_AXI_ARREADY) arvalid_d = 1'b0;
            if (M_AXI_RVALID && rready_q) begin
               fail = (M_AXI_RDATA != pat_data) || (M_AXI_RRESP != OKAY);
               if (last_beat) begin
                  state_d  = DONE;
                  rready_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  pat_adv   = 1'b1;
                  araddr_d  = araddr_q + STEP;
                  arvalid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (fail) begin
         error_d = 1'b1;
         if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         init_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         err_cnt_q <= '0;
         issue_q   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= BASE_ADDR;
         araddr_q  <= BASE_ADDR;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         err_cnt_q <= err_cnt_d;
         issue_q   <= issue_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign BUSY          = busy_q;
   assign TXN_DONE      = done_q;
   assign ERROR         = error_q;
   assign ERR_COUNT     = err_cnt_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = {(DATA_WIDTH/8){1'b1}};
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_ptgen_master.sv
// Bench for axil_ptgen_master: three differently configured masters, each with an
// inline AXI-Lite memory slave that can stall, corrupt read data or return SLVERR.
module tb_axil_ptgen_master;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] init_v = 3'b000;
   logic [2:0] done_v;

   bit          bp_en       [3] = '{0, 0, 0};
   int          slverr_beat [3] = '{-1, -1, -1};
   logic [15:0] corrupt     [3] = '{16'h0, 16'h0, 16'h0};
   int          dly_tab     [8] = '{0, 3, 7, 1, 5, 2, 6, 4};

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int DW  = (g == 1) ? 64 : 32;
      localparam int NT  = (g == 1) ? 16 : ((g == 2) ? 8 : 4);
      localparam int PAT = (g == 1) ? 1 : 0;
      localparam int EW  = (g == 2) ? 2 : 8;
      localparam int BY  = DW / 8;

      logic          busy, done, err;
      logic [EW-1:0] errc;
      logic [31:0]   awaddr, araddr;
      logic [2:0]    awprot, arprot;
      logic          awvalid, awready, wvalid, wready, bvalid, bready;
      logic          arvalid, arready, rvalid, rready;
      logic [DW-1:0] wdata, rdata;
      logic [BY-1:0] wstrb;
      logic [1:0]    bresp, rresp;

      axil_ptgen_master #(
         .ADDR_WIDTH (32),
         .DATA_WIDTH (DW),
         .NUM_TXN    (NT),
         .BASE_ADDR  (BASE),
         .PATTERN    (PAT),
         .SEED       (64'hACE1),
         .ERR_CNT_W  (EW)
      ) dut (
         .ACLK          (clk),
         .ARESET        (rst),
         .INIT_TXN      (init_v[g]),
         .BUSY          (busy),
         .TXN_DONE      (done),
         .ERROR         (err),
         .ERR_COUNT     (errc),
         .M_AXI_AWADDR  (awaddr),
         .M_AXI_AWPROT  (awprot),
         .M_AXI_AWVALID (awvalid),
         .M_AXI_AWREADY (awready),
         .M_AXI_WDATA   (wdata),
         .M_AXI_WSTRB   (wstrb),
         .M_AXI_WVALID  (wvalid),
         .M_AXI_WREADY  (wready),
         .M_AXI_BRESP   (bresp),
         .M_AXI_BVALID  (bvalid),
         .M_AXI_BREADY  (bready),
         .M_AXI_ARADDR  (araddr),
         .M_AXI_ARPROT  (arprot),
         .M_AXI_ARVALID (arvalid),
         .M_AXI_ARREADY (arready),
         .M_AXI_RDATA   (rdata),
         .M_AXI_RRESP   (rresp),
         .M_AXI_RVALID  (rvalid),
         .M_AXI_RREADY  (rready)
      );

      assign done_v[g] = done;

      logic [63:0]   mem    [16];
      logic [31:0]   wlog_a [16];
      logic [63:0]   wlog_d [16];
      logic [31:0]   rlog_a [16];
      int            wcnt, rcnt, stab_err, aw_first, w_first;
      int            aw_wait, w_wait, ar_wait, aw_dly, w_dly, ar_dly;
      logic          aw_got, w_got, aw_pend, w_pend, ar_pend;
      logic          aw_hs, w_hs, ar_hs;
      logic [31:0]   aw_a, aw_hold, ar_hold, cur_a, cur_off, ar_off;
      logic [DW-1:0] w_d, w_hold, cur_d;

      assign aw_dly  = bp_en[g] ? dly_tab[wcnt % 8] : 0;
      assign w_dly   = bp_en[g] ? dly_tab[(wcnt + 3) % 8] : 0;
      assign ar_dly  = bp_en[g] ? dly_tab[(rcnt + 5) % 8] : 0;
      assign awready = awvalid && !aw_got && (aw_wait >= aw_dly);
      assign wready  = wvalid && !w_got && (w_wait >= w_dly);
      assign arready = arvalid && (ar_wait >= ar_dly);
      assign aw_hs   = awvalid && awready;
      assign w_hs    = wvalid && wready;
      assign ar_hs   = arvalid && arready;
      assign cur_a   = aw_got ? aw_a : awaddr;
      assign cur_d   = w_got ? w_d : wdata;
      assign cur_off = (cur_a - BASE) / BY;
      assign ar_off  = (araddr - BASE) / BY;

      always @(posedge clk) begin
         if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; wcnt <= 0; rcnt <= 0;
            aw_first <= 0; w_first <= 0; stab_err <= 0;
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
         end else begin
            // A stalled VALID must stay up with an unchanged payload.
            aw_pend <= awvalid && !awready; aw_hold <= awaddr;
            w_pend  <= wvalid && !wready;   w_hold  <= wdata;
            ar_pend <= arvalid && !arready; ar_hold <= araddr;
            if ((aw_pend && (!awvalid || awaddr != aw_hold)) ||
                (w_pend && (!wvalid || wdata != w_hold)) ||
                (ar_pend && (!arvalid || araddr != ar_hold)))
               stab_err <= stab_err + 1;
            aw_wait <= aw_hs ? 0 : (awvalid ? aw_wait + 1 : aw_wait);
            w_wait  <= w_hs ? 0 : (wvalid ? w_wait + 1 : w_wait);
            ar_wait <= ar_hs ? 0 : (arvalid ? ar_wait + 1 : ar_wait);
            if (aw_hs && !w_got && !w_hs) aw_first <= aw_first + 1;
            if (w_hs && !aw_got && !aw_hs) w_first <= w_first + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
               bvalid <= 1'b1;
               bresp  <= (wcnt == slverr_beat[g]) ? 2'b10 : 2'b00;
               mem[cur_off[3:0]] <= 64'(cur_d);
               if (wcnt < 16) begin
                  wlog_a[wcnt] <= cur_a;
                  wlog_d[wcnt] <= 64'(cur_d);
               end
               wcnt   <= wcnt + 1;
               aw_got <= 1'b0;
               w_got  <= 1'b0;
            end else begin
               if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; end
               if (w_hs)  begin w_got  <= 1'b1; w_d  <= wdata;  end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (ar_hs) begin
               rvalid <= 1'b1;
               rresp  <= 2'b00;
               rdata  <= DW'(mem[ar_off[3:0]] ^ (corrupt[g][rcnt % 16] ? 64'hFF : 64'h0));
               if (rcnt < 16) rlog_a[rcnt] <= araddr;
               rcnt <= rcnt + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_lfsr64(input logic [63:0] s);
      return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse INIT on instance k, optionally re-pulse it at cycle 'poke', wait for TXN_DONE.
   task automatic run(input int k, input int lim, input int poke, output int n);
      init_v[k] = 1'b1;
      n = 0;
      while (!done_v[k] && n < lim) begin
         @(negedge clk);
         n++;
         init_v[k] = (n == poke);
      end
      init_v[k] = 1'b0;
   endtask

   initial begin
      int          n;
      logic [63:0] m;

      do_reset();
      chk("rst_busy",    u[0].busy,    0);
      chk("rst_done",    u[0].done,    0);
      chk("rst_error",   u[0].err,     0);
      chk("rst_errcnt",  u[0].errc,    0);
      chk("rst_awvalid", u[0].awvalid, 0);
      chk("rst_wvalid",  u[0].wvalid,  0);
      chk("rst_arvalid", u[0].arvalid, 0);
      chk("rst_bready",  u[0].bready,  0);
      chk("rst_rready",  u[0].rready,  0);
      chk("rst_awaddr",  u[0].awaddr,  32'h4000_0000);
      chk("rst_araddr",  u[0].araddr,  32'h4000_0000);
      chk("rst_wdata",   u[0].wdata,   0);
      chk("wstrb32",     u[0].wstrb,   4'hF);
      chk("wstrb64",     u[1].wstrb,   8'hFF);
      chk("prot",        {u[0].awprot, u[0].arprot, u[1].awprot, u[2].arprot}, 0);

      // 1: default incrementing pattern, zero-wait slave
      run(0, 300, 0, n);
      chk("t1_latency", n, 21);
      chk("t1_done",    u[0].done, 1);
      chk("t1_busy",    u[0].busy, 0);
      chk("t1_error",   u[0].err,  0);
      chk("t1_errcnt",  u[0].errc, 0);
      chk("t1_wcnt",    u[0].wcnt, 4);
      chk("t1_rcnt",    u[0].rcnt, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_waddr%0d", i), u[0].wlog_a[i], 32'h4000_0000 + 32'(4 * i));
         chk($sformatf("t1_wdata%0d", i), u[0].wlog_d[i], 64'(i + 1));
         chk($sformatf("t1_raddr%0d", i), u[0].rlog_a[i], 32'h4000_0000 + 32'(4 * i));
      end

      // 2: 64-bit LFSR pattern, 16 beats
      run(1, 800, 0, n);
      chk("t2_done",   u[1].done, 1);
      chk("t2_error",  u[1].err,  0);
      chk("t2_errcnt", u[1].errc, 0);
      chk("t2_wcnt",   u[1].wcnt, 16);
      chk("t2_rcnt",   u[1].rcnt, 16);
      m = 64'hACE1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t2_waddr%0d", i), u[1].wlog_a[i], 32'h4000_0000 + 32'(8 * i));
         chk($sformatf("t2_wdata%0d", i), u[1].wlog_d[i], m);
         chk($sformatf("t2_raddr%0d", i), u[1].rlog_a[i], 32'h4000_0000 + 32'(8 * i));
         m = ref_lfsr64(m);
      end

      // 3: SLVERR on write beat 0 plus corrupted read beat 2
      do_reset();
      slverr_beat[0] = 0;
      corrupt[0]     = 16'h0004;
      run(0, 300, 0, n);
      chk("t3_done",   u[0].done, 1);
      chk("t3_error",  u[0].err,  1);
      chk("t3_errcnt", u[0].errc, 2);
      slverr_beat[0] = -1;
      corrupt[0]     = 16'h0;

      // 4: every read corrupted, 2-bit counter saturates
      corrupt[2] = 16'h00FF;
      run(2, 400, 0, n);
      chk("t4_done",   u[2].done, 1);
      chk("t4_error",  u[2].err,  1);
      chk("t4_errcnt", u[2].errc, 3);
      chk("t4_rcnt",   u[2].rcnt, 8);
      corrupt[2] = 16'h0;

      // 5: READY back-pressure on AW/W/AR
      do_reset();
      bp_en[0] = 1;
      run(0, 600, 0, n);
      chk("t5_done",     u[0].done,         1);
      chk("t5_error",    u[0].err,          0);
      chk("t5_errcnt",   u[0].errc,         0);
      chk("t5_stable",   u[0].stab_err,     0);
      chk("t5_aw_first", u[0].aw_first > 0, 1);
      chk("t5_w_first",  u[0].w_first > 0,  1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t5_wdata%0d", i), u[0].wlog_d[i], 64'(i + 1));
      bp_en[0] = 0;

      // 6: reset during write beat 1, then a fresh run with a mid-run INIT pulse
      do_reset();
      init_v[0] = 1'b1;
      @(negedge clk);
      init_v[0] = 1'b0;
      n = 0;
      while (!(u[0].wcnt == 1 && u[0].awvalid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_beat1_seen", u[0].awvalid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_awvalid", u[0].awvalid, 0);
      chk("t6_wvalid",  u[0].wvalid,  0);
      chk("t6_arvalid", u[0].arvalid, 0);
      chk("t6_bready",  u[0].bready,  0);
      chk("t6_busy",    u[0].busy,    0);
      @(negedge clk);
      rst = 1'b0;
      run(0, 300, 6, n);
      chk("t6_latency", n, 21);
      chk("t6_done",    u[0].done, 1);
      chk("t6_wcnt",    u[0].wcnt, 4);
      chk("t6_rcnt",    u[0].rcnt, 4);
      chk("t6_error",   u[0].err,  0);
      chk("t6_errcnt",  u[0].errc, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
